// File: rtl/node_issue_scheduler_pkg.sv
// Shared types and parameters for the E-node issue path.
//   FRAMES_PER_NODE : default reservation-station frame count per E-node
//   sched_state_e   : issue scheduler FSM state encoding
package node_issue_scheduler_pkg;

  localparam int FRAMES_PER_NODE = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_BUSY  = 2'd2
  } sched_state_e;

endpackage

// File: rtl/rr_pick_first.sv
// Round-robin first-set pick: returns the first set bit of vec at or after
// ptr, wrapping from N-1 to 0. N must be a power of two.
//   vec   : request vector
//   ptr   : starting priority position
//   idx   : index of the winning bit (0 when none)
//   found : any bit of vec set
module rr_pick_first #(
  parameter  int N  = 8,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  vec,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          found
);

  logic [IW-1:0] pos;

  // Walk offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      pos = ptr + IW'(i);
      if (vec[pos]) begin
        idx   = pos;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/node_issue_scheduler.sv
// Per-E-node issue scheduler: picks a fire-ready reservation-station frame
// round-robin, offers it to the ALU with a valid/ready handshake, and holds
// off further offers while a multi-cycle op occupies the ALU.
//   clk, rst_n    : clock, synchronous active-low reset
//   ready_vec     : per-frame fire-ready
//   frame_en      : frames owned by the active partition
//   issue_valid   : offer pending; issue_frame is the offered frame
//   issue_ready   : ALU accepts; issue_lat is its occupancy (0 means 1)
//   fired_clr     : one-hot clear of the issued frame's operands (comb)
//   flush         : flush frames in flush_mask
//   issue_count   : saturating count of accepted issues
module node_issue_scheduler
  import node_issue_scheduler_pkg::*;
#(
  parameter  int FRAMES = FRAMES_PER_NODE,
  parameter  int LAT_W  = 4,
  localparam int FW     = $clog2(FRAMES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FRAMES-1:0] ready_vec,
  input  logic [FRAMES-1:0] frame_en,
  output logic              issue_valid,
  output logic [FW-1:0]     issue_frame,
  input  logic              issue_ready,
  input  logic [LAT_W-1:0]  issue_lat,
  output logic [FRAMES-1:0] fired_clr,
  input  logic              flush,
  input  logic [FRAMES-1:0] flush_mask,
  output logic [15:0]       issue_count
);

  sched_state_e      state_q, state_d;
  logic [FW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [FW-1:0]     frame_q, frame_d;
  logic [LAT_W-1:0]  busy_cnt_q, busy_cnt_d;
  logic [15:0]       count_q, count_d;

  logic [FRAMES-1:0] cand, cand_rest, frame_oh;
  logic [FW-1:0]     pick_idx, rest_idx, next_ptr;
  logic              pick_found, rest_found, hs;
  logic [LAT_W-1:0]  lat_eff;

  always_comb begin
    cand      = ready_vec & frame_en & ~(flush ? flush_mask : '0);
    frame_oh  = FRAMES'(1) << frame_q;
    cand_rest = cand & ~frame_oh;
    next_ptr  = frame_q + FW'(1);
    lat_eff   = (issue_lat == '0) ? LAT_W'(1) : issue_lat;
  end

  // Fresh pick from IDLE uses the stored pointer.
  rr_pick_first #(.N(FRAMES)) u_pick (
    .vec(cand), .ptr(rr_ptr_q), .idx(pick_idx), .found(pick_found)
  );

  // Back-to-back pick uses the pointer as it will be after this handshake;
  // the granted frame is excluded so it cannot be re-offered immediately.
  rr_pick_first #(.N(FRAMES)) u_pick_next (
    .vec(cand_rest), .ptr(next_ptr), .idx(rest_idx), .found(rest_found)
  );

  // Gating on cand[frame] makes a flush of the offered frame (or a dropped
  // ready/enable bit) win over issue_ready.
  assign hs = rst_n && (state_q == ST_OFFER) && issue_ready && cand[frame_q];

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    frame_d    = frame_q;
    busy_cnt_d = busy_cnt_q;
    count_d    = count_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          frame_d = pick_idx;
          state_d = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (hs) begin
          rr_ptr_d = next_ptr;
          count_d  = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
          if (lat_eff == LAT_W'(1)) begin
            if (rest_found) frame_d = rest_idx;
            else            state_d = ST_IDLE;
          end else begin
            busy_cnt_d = lat_eff - LAT_W'(1);
            state_d    = ST_BUSY;
          end
        end else if (!cand[frame_q]) begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        busy_cnt_d = busy_cnt_q - LAT_W'(1);
        if (busy_cnt_q <= LAT_W'(1)) begin
          busy_cnt_d = '0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      frame_q    <= '0;
      busy_cnt_q <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      frame_q    <= frame_d;
      busy_cnt_q <= busy_cnt_d;
      count_q    <= count_d;
    end
  end

  assign issue_valid = (state_q == ST_OFFER);
  assign issue_frame = frame_q;
  assign issue_count = count_q;
  assign fired_clr   = hs ? frame_oh : '0;

endmodule

// File: tb/tb_node_issue_scheduler.sv
module tb_node_issue_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ready_vec, frame_en, flush_mask, fired_clr;
  logic       issue_valid, issue_ready, flush;
  logic [2:0] issue_frame;
  logic [3:0] issue_lat;
  logic [15:0] issue_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  node_issue_scheduler #(.FRAMES(8), .LAT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .ready_vec(ready_vec), .frame_en(frame_en),
    .issue_valid(issue_valid), .issue_frame(issue_frame),
    .issue_ready(issue_ready), .issue_lat(issue_lat), .fired_clr(fired_clr),
    .flush(flush), .flush_mask(flush_mask), .issue_count(issue_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ready_vec = 8'h00; flush = 1'b0; flush_mask = 8'h00;
    frame_en = 8'hFF;
    tick(); tick();
    rst_n = 1'b1;
    #1;
  endtask

  logic [2:0] exp_seq [4];

  initial begin
    rst_n = 1'b0; ready_vec = 8'hFF; frame_en = 8'hFF; issue_ready = 1'b1;
    issue_lat = 4'd1; flush = 1'b0; flush_mask = 8'h00;
    tick(); tick();
    check("rst_valid", 32'(issue_valid), 32'd0);
    check("rst_frame", 32'(issue_frame), 32'd0);
    check("rst_count", 32'(issue_count), 32'd0);
    check("rst_fired", 32'(fired_clr), 32'd0);

    // Single issue, one-cycle latency from ready to offer
    rst_n = 1'b1; ready_vec = 8'h01; #1;
    check("t1_idle_valid", 32'(issue_valid), 32'd0);
    tick();
    check("t1_valid", 32'(issue_valid), 32'd1);
    check("t1_frame", 32'(issue_frame), 32'd0);
    check("t1_fired", 32'(fired_clr), 32'h01);
    tick();
    check("t1_count", 32'(issue_count), 32'd1);
    check("t1_back_idle", 32'(issue_valid), 32'd0);

    // Back-to-back round robin over 0,3,7
    do_reset();
    ready_vec = 8'h89; issue_ready = 1'b1; issue_lat = 4'd1;
    tick();
    exp_seq[0] = 3'd0; exp_seq[1] = 3'd3; exp_seq[2] = 3'd7; exp_seq[3] = 3'd0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_valid%0d", i), 32'(issue_valid), 32'd1);
      check($sformatf("t2_frame%0d", i), 32'(issue_frame), 32'(exp_seq[i]));
      check($sformatf("t2_fired%0d", i), 32'(fired_clr), 32'(8'h01 << exp_seq[i]));
      tick();
    end
    check("t2_count", 32'(issue_count), 32'd4);

    // Stalled offer holds its frame
    do_reset();
    ready_vec = 8'h04; issue_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t3_frame%0d", i), 32'(issue_frame), 32'd2);
      check($sformatf("t3_fired%0d", i), 32'(fired_clr), 32'd0);
      tick();
    end
    check("t3_count_stall", 32'(issue_count), 32'd0);
    issue_ready = 1'b1; #1;
    check("t3_fired_hs", 32'(fired_clr), 32'h04);
    tick();
    check("t3_count", 32'(issue_count), 32'd1);

    // Multi-cycle ALU occupancy
    do_reset();
    ready_vec = 8'hFF; issue_ready = 1'b1; issue_lat = 4'd4;
    tick();
    check("t4_fired", 32'(fired_clr), 32'h01);
    tick();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t4_busy_valid%0d", i), 32'(issue_valid), 32'd0);
      check($sformatf("t4_busy_fired%0d", i), 32'(fired_clr), 32'd0);
      tick();
    end
    check("t4_idle_valid", 32'(issue_valid), 32'd0);
    check("t4_count", 32'(issue_count), 32'd1);
    tick();
    check("t4_reoffer_valid", 32'(issue_valid), 32'd1);
    check("t4_reoffer_frame", 32'(issue_frame), 32'd1);
    issue_lat = 4'd0; #1;
    tick();
    check("t4_lat0_b2b_valid", 32'(issue_valid), 32'd1);
    check("t4_lat0_b2b_frame", 32'(issue_frame), 32'd2);

    // Flush of offered frame beats issue_ready
    do_reset();
    ready_vec = 8'h20; issue_ready = 1'b0; issue_lat = 4'd1;
    tick();
    check("t5_offer_frame", 32'(issue_frame), 32'd5);
    flush = 1'b1; flush_mask = 8'h20; issue_ready = 1'b1; #1;
    check("t5_flush_fired", 32'(fired_clr), 32'd0);
    tick();
    check("t5_flush_idle", 32'(issue_valid), 32'd0);
    check("t5_flush_count", 32'(issue_count), 32'd0);
    flush = 1'b0; flush_mask = 8'h00;
    frame_en = 8'h0F; ready_vec = 8'hF0; #1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("t5_masked_valid%0d", i), 32'(issue_valid), 32'd0);
    end
    frame_en = 8'hFF;

    // Saturation, then reset during BUSY
    do_reset();
    ready_vec = 8'hFF; issue_ready = 1'b1; issue_lat = 4'd1;
    tick();
    repeat (65540) tick();
    check("t6_sat", 32'(issue_count), 32'hFFFF);
    issue_lat = 4'd4; #1;
    tick();
    check("t6_busy_valid", 32'(issue_valid), 32'd0);
    check("t6_busy_count", 32'(issue_count), 32'hFFFF);
    rst_n = 1'b0; #1;
    check("t6_rst_fired", 32'(fired_clr), 32'd0);
    tick();
    check("t6_rst_count", 32'(issue_count), 32'd0);
    check("t6_rst_valid", 32'(issue_valid), 32'd0);
    rst_n = 1'b1; #1;
    tick();
    check("t6_post_rst_valid", 32'(issue_valid), 32'd1);
    check("t6_post_rst_frame", 32'(issue_frame), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/node_issue_scheduler.md
NODE_ISSUE_SCHEDULER -- requirements
Module: node_issue_scheduler

Interface
REQ-001 Parameter FRAMES, default `FRAMES_PER_NODE (8): reservation-station frames per E-node; SHALL be a power of two, at least 2.
REQ-002 Parameter LAT_W, default 4: width of the ALU occupancy-latency field.
REQ-003 Port clk  in  1  sole clock; all state SHALL update on the rising edge.
REQ-004 Port rst_n  in  1  reset, synchronous, active-low.
REQ-005 Port ready_vec  in  FRAMES  per-frame fire-ready (all required operands valid).
REQ-006 Port frame_en  in  FRAMES  frames owned by the active partition (T-morph mask); 0 excludes the frame.
REQ-007 Port issue_valid  out  1  an offer to the ALU is pending.
REQ-008 Port issue_frame  out  $clog2(FRAMES)  frame index offered.
REQ-009 Port issue_ready  in  1  ALU accepts the offer this cycle.
REQ-010 Port issue_lat  in  LAT_W  ALU occupancy in cycles for the offered op, sampled at handshake; 0 is treated as 1.
REQ-011 Port fired_clr  out  FRAMES  one-hot; tells the reservation station to clear that frame's operand valids.
REQ-012 Port flush  in  1  block flush request.
REQ-013 Port flush_mask  in  FRAMES  frames flushed when flush=1.
REQ-014 Port issue_count  out  16  count of accepted issues, saturating.

Function
REQ-015 Handshake: an issue SHALL occur in a cycle where issue_valid=1 and issue_ready=1.
REQ-016 fired_clr SHALL be combinational: one-hot at issue_frame in a handshake cycle, otherwise all zeros.
REQ-017 Candidates SHALL be ready_vec & frame_en & ~flush_term, where flush_term is flush_mask when flush=1 and 0 otherwise.
REQ-018 Selection SHALL be round-robin: the first candidate at or after rr_ptr, wrapping from FRAMES-1 to 0.
REQ-019 On handshake, rr_ptr SHALL become (issue_frame+1) mod FRAMES.
REQ-020 FSM states SHALL be IDLE, OFFER and BUSY.
REQ-021 IDLE: if any candidate exists, latch the selected frame into issue_frame and go to OFFER next cycle; issue_valid goes high 1 cycle after ready_vec rises.
REQ-022 OFFER: issue_valid=1; issue_frame SHALL stay stable until handshake or withdrawal.
REQ-023 OFFER withdrawal: if the offered frame is flushed, or its ready_vec or frame_en bit is 0, with no handshake in that cycle, go to IDLE.
REQ-024 Flush takes priority over issue_ready in the same cycle: there is no handshake and fired_clr=0.
REQ-025 OFFER handshake with effective latency 1: if any candidate other than the granted frame exists, choose from the updated rr_ptr and stay in OFFER (back-to-back issue); otherwise go to IDLE.
REQ-026 OFFER handshake with effective latency L>1: load busy_cnt=L-1 and go to BUSY.
REQ-027 BUSY: issue_valid=0; busy_cnt decrements each cycle; on reaching 0, go to IDLE.
REQ-028 BUSY is not aborted by flush.
REQ-029 issue_count SHALL increment by 1 per handshake and saturate at 16'hFFFF.
REQ-030 All frames masked by frame_en: the scheduler SHALL never offer, regardless of ready_vec.

Reset
REQ-031 When rst_n=0 at a clock edge, the following SHALL be cleared: state=IDLE, rr_ptr=0, busy_cnt=0, issue_valid=0, issue_frame=0, issue_count=0.
REQ-032 fired_clr SHALL be 0 throughout reset.
REQ-033 Reset SHALL abandon any OFFER or BUSY immediately.

Structure
REQ-034 The FSM state enum and `FRAMES_PER_NODE SHALL live in the shared trips types/params includes.
REQ-035 Round-robin priority pick SHALL be one sub-module, rr_pick_first (inputs vector and pointer; outputs index and found), reusable by other node arbiters.

Verification
REQ-036 Reset, then ready_vec=8'h01, frame_en=8'hFF, issue_ready=1, issue_lat=1 -> issue_valid at cycle 1 with issue_frame=0, fired_clr=8'h01, issue_count=1.
REQ-037 ready_vec=8'h89 held, issue_ready=1, lat=1 -> back-to-back frames 0,3,7,0; one handshake per cycle after the first offer.
REQ-038 Offer frame 2, issue_ready=0 for 3 cycles -> issue_frame stays 2, fired_clr=0; then issue_ready=1 -> one handshake.
REQ-039 Handshake with issue_lat=4 -> BUSY for 3 cycles with issue_valid=0 even though ready_vec=8'hFF; next offer 1 cycle after BUSY ends, at frame+1.
REQ-040 Offering frame 5, flush=1, flush_mask=8'h20, issue_ready=1 -> no handshake, fired_clr=0, IDLE next cycle; frame_en=8'h0F, ready_vec=8'hF0 -> never offers.
REQ-041 issue_count preloaded near saturation (drive 65540 handshakes) -> holds at 16'hFFFF; rst_n=0 during BUSY -> IDLE and count 0 next cycle.
